// File: rtl/compressed_fetch_sequencer_pkg.sv
// Shared core package for the compressed fetch sequencer and its decoder.
// Holds the sequencer state encoding, the PC write mode encoding and the
// LSU access width encoding so producer and consumer agree on the values.
package compressed_fetch_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_FETCH    = 2'b00,
        ST_EXECUTE  = 2'b01,
        ST_LSU_WAIT = 2'b10,
        ST_HALT     = 2'b11
    } seq_state_e;

    typedef enum logic [1:0] {
        PC_INC      = 2'b00,
        PC_BRANCH   = 2'b01,
        PC_JUMP_REG = 2'b10,
        PC_JUMP_IMM = 2'b11
    } pc_mode_e;

    typedef enum logic [1:0] {
        LSU_NONE = 2'b00,
        LSU_BYTE = 2'b01,
        LSU_HALF = 2'b10,
        LSU_WORD = 2'b11
    } lsu_width_e;

endpackage

// File: rtl/compressed_fetch_sequencer_next_pc_calc.sv
// next_pc_calc: combinational next-PC selection for the fetch sequencer.
// Ports:
//   pc              current instruction address
//   mode            PC write mode (Inc / Branch / JumpReg / JumpImm)
//   imm             decoder immediate, added to pc for branches and JumpImm
//   branch_taken    ALU flag selecting the branch target
//   jump_reg_target rs1 value used by JumpReg
//   next_pc         selected next PC, bit 0 always cleared
module next_pc_calc
    import compressed_fetch_sequencer_pkg::*;
(
    input  logic [31:0] pc,
    input  pc_mode_e    mode,
    input  logic [31:0] imm,
    input  logic        branch_taken,
    input  logic [31:0] jump_reg_target,
    output logic [31:0] next_pc
);

    logic [31:0] seq_pc;
    logic [31:0] rel_pc;
    logic [31:0] raw_pc;

    always_comb begin
        seq_pc = pc + 32'd2;
        rel_pc = pc + imm;
        raw_pc = seq_pc;
        case (mode)
            PC_INC:      raw_pc = seq_pc;
            PC_BRANCH:   raw_pc = branch_taken ? rel_pc : seq_pc;
            PC_JUMP_REG: raw_pc = jump_reg_target;
            PC_JUMP_IMM: raw_pc = rel_pc;
            default:     raw_pc = seq_pc;
        endcase
        // Halfword-aligned instruction stream: odd targets are truncated.
        next_pc = raw_pc & ~32'd1;
    end

endmodule

// File: rtl/compressed_fetch_sequencer.sv
// compressed_fetch_sequencer: fetches 32-bit words, feeds 16-bit compressed
// instructions to the decoder one at a time and sequences the PC, register
// writeback strobe and LSU handshake. The unused upper halfword of a word
// fetched at a low-half PC is kept in a one-entry buffer so the following
// sequential instruction needs no memory access.
// Ports:
//   Clock, Reset          rising-edge clock, synchronous active-high reset
//   IReq/IAddr/IReady/IData  instruction fetch handshake (word aligned)
//   InstrOut/InstrValid   halfword to the decoder, valid in EXECUTE
//   PC/LinkAddr           address of InstrOut and PC+2 for link writeback
//   Ctl*/ImmIn/BranchTaken/JumpRegTarget  decoder and ALU results
//   RegWriteEn            writeback strobe for non-LSU instructions
//   LsuReq/LsuDone        load/store start pulse and completion
//   Halted                stopped on an illegal instruction until Reset
module compressed_fetch_sequencer
    import compressed_fetch_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clock,
    input  logic        Reset,
    output logic        IReq,
    output logic [31:0] IAddr,
    input  logic        IReady,
    input  logic [31:0] IData,
    output logic [15:0] InstrOut,
    output logic        InstrValid,
    output logic [31:0] PC,
    output logic [31:0] LinkAddr,
    input  logic        CtlValid,
    input  logic [1:0]  CtlPCMode,
    input  logic [1:0]  CtlLsuWidth,
    input  logic [31:0] ImmIn,
    input  logic        BranchTaken,
    input  logic [31:0] JumpRegTarget,
    output logic        RegWriteEn,
    output logic        LsuReq,
    input  logic        LsuDone,
    output logic        Halted
);

    seq_state_e  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [15:0] instr_q, instr_d;
    logic        buf_valid_q, buf_valid_d;
    logic [29:0] buf_word_q, buf_word_d;
    logic [15:0] buf_half_q, buf_half_d;
    // High for the first cycle after reset so no fetch starts in that cycle.
    logic        reset_hold_q, reset_hold_d;

    pc_mode_e    pc_mode;
    logic [31:0] next_pc;
    logic        buf_hit;
    logic        seq_update;

    assign pc_mode = pc_mode_e'(CtlPCMode);

    next_pc_calc u_next_pc_calc (
        .pc              (pc_q),
        .mode            (pc_mode),
        .imm             (ImmIn),
        .branch_taken    (BranchTaken),
        .jump_reg_target (JumpRegTarget),
        .next_pc         (next_pc)
    );

    assign IAddr    = {pc_q[31:2], 2'b00};
    assign PC       = pc_q;
    assign LinkAddr = pc_q + 32'd2;
    assign InstrOut = instr_q;

    assign buf_hit    = buf_valid_q && (buf_word_q == pc_q[31:2]) && pc_q[1];
    // Only the fall-through path keeps the buffered halfword.
    assign seq_update = (pc_mode == PC_INC) || ((pc_mode == PC_BRANCH) && !BranchTaken);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        buf_valid_d  = buf_valid_q;
        buf_word_d   = buf_word_q;
        buf_half_d   = buf_half_q;
        reset_hold_d = 1'b0;
        IReq         = 1'b0;
        InstrValid   = 1'b0;
        RegWriteEn   = 1'b0;
        LsuReq       = 1'b0;
        Halted       = 1'b0;

        case (state_q)
            ST_FETCH: begin
                if (!reset_hold_q) begin
                    if (buf_hit) begin
                        instr_d     = buf_half_q;
                        buf_valid_d = 1'b0;
                        state_d     = ST_EXECUTE;
                    end else begin
                        IReq = 1'b1;
                        if (IReady) begin
                            state_d = ST_EXECUTE;
                            if (pc_q[1]) begin
                                instr_d = IData[31:16];
                            end else begin
                                instr_d     = IData[15:0];
                                buf_half_d  = IData[31:16];
                                buf_word_d  = pc_q[31:2];
                                buf_valid_d = 1'b1;
                            end
                        end
                    end
                end
            end
            ST_EXECUTE: begin
                InstrValid = 1'b1;
                if (!CtlValid) begin
                    state_d = ST_HALT;
                end else if (lsu_width_e'(CtlLsuWidth) != LSU_NONE) begin
                    // LsuDone is not looked at here, so a same-cycle done is ignored.
                    LsuReq  = 1'b1;
                    state_d = ST_LSU_WAIT;
                end else begin
                    RegWriteEn = 1'b1;
                    pc_d       = next_pc;
                    state_d    = ST_FETCH;
                    if (!seq_update) begin
                        buf_valid_d = 1'b0;
                    end
                end
            end
            ST_LSU_WAIT: begin
                if (LsuDone) begin
                    pc_d    = pc_q + 32'd2;
                    state_d = ST_FETCH;
                end
            end
            ST_HALT: begin
                Halted = 1'b1;
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q      <= ST_FETCH;
            pc_q         <= RESET_PC & ~32'd1;
            instr_q      <= 16'h0000;
            buf_valid_q  <= 1'b0;
            reset_hold_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            buf_valid_q  <= buf_valid_d;
            reset_hold_q <= reset_hold_d;
        end
    end

    // Buffer payload is qualified by buf_valid_q and needs no reset.
    always_ff @(posedge Clock) begin
        buf_word_q <= buf_word_d;
        buf_half_q <= buf_half_d;
    end

endmodule

// File: tb/tb_compressed_fetch_sequencer.sv
module tb_compressed_fetch_sequencer;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        IReq;
    logic [31:0] IAddr;
    logic        IReady;
    logic [31:0] IData;
    logic [15:0] InstrOut;
    logic        InstrValid;
    logic [31:0] PC;
    logic [31:0] LinkAddr;
    logic        CtlValid;
    logic [1:0]  CtlPCMode;
    logic [1:0]  CtlLsuWidth;
    logic [31:0] ImmIn;
    logic        BranchTaken;
    logic [31:0] JumpRegTarget;
    logic        RegWriteEn;
    logic        LsuReq;
    logic        LsuDone;
    logic        Halted;

    int total = 0;
    int bad   = 0;

    // Reference model state: program counter and the one-word halfword buffer.
    logic [31:0] m_pc;
    bit          m_buf_valid;
    logic [29:0] m_buf_word;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    compressed_fetch_sequencer #(.RESET_PC(RST_PC)) dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .IReq          (IReq),
        .IAddr         (IAddr),
        .IReady        (IReady),
        .IData         (IData),
        .InstrOut      (InstrOut),
        .InstrValid    (InstrValid),
        .PC            (PC),
        .LinkAddr      (LinkAddr),
        .CtlValid      (CtlValid),
        .CtlPCMode     (CtlPCMode),
        .CtlLsuWidth   (CtlLsuWidth),
        .ImmIn         (ImmIn),
        .BranchTaken   (BranchTaken),
        .JumpRegTarget (JumpRegTarget),
        .RegWriteEn    (RegWriteEn),
        .LsuReq        (LsuReq),
        .LsuDone       (LsuDone),
        .Halted        (Halted)
    );

    always #5 Clock = ~Clock;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Instruction memory contents as a pure function of the word address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h4501_4081;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234 ^ {a[15:0], a[31:16]};
    endfunction

    // Architectural next PC, straight from the PC rules.
    function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [1:0] mode,
                                               input logic [31:0] imm, input bit taken,
                                               input logic [31:0] target);
        logic [31:0] r;
        case (mode)
            2'd0:    r = pc + 2;
            2'd1:    r = taken ? pc + imm : pc + 2;
            2'd2:    r = target;
            default: r = pc + imm;
        endcase
        return r & ~32'd1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic clear_inputs();
        IReady = 0; IData = 0; CtlValid = 0; CtlPCMode = 0; CtlLsuWidth = 0;
        ImmIn = 0; BranchTaken = 0; JumpRegTarget = 0; LsuDone = 0;
    endtask

    task automatic idle_checks(input string tag);
        chk({tag, "_lsureq"}, LsuReq, 0);
        chk({tag, "_regwe"}, RegWriteEn, 0);
        chk({tag, "_ivalid"}, InstrValid, 0);
    endtask

    task automatic do_reset();
        clear_inputs();
        Reset = 1;
        tick();
        #1;
        chk("rst_ireq", IReq, 0);
        idle_checks("rst");
        chk("rst_halted", Halted, 0);
        chk("rst_instr", InstrOut, 16'h0000);
        chk("rst_pc", PC, RST_PC);
        Reset = 0;
        #1;
        chk("rst_hold_ireq", IReq, 0);
        tick();
        m_pc = RST_PC;
        m_buf_valid = 0;
    endtask

    // One instruction: fetch (hit or miss with wait_cyc stalls), execute, and
    // optionally the LSU wait. Entered and left just after a rising edge.
    task automatic run_instr(input int wait_cyc, input bit ctl_valid, input logic [1:0] mode,
                             input logic [31:0] imm, input bit taken, input logic [31:0] target,
                             input logic [1:0] lsu, input int lsu_wait, input bit abort_lsu);
        logic [31:0] word;
        logic [15:0] exp_instr;
        bit          hit;
        hit  = m_buf_valid && (m_buf_word == m_pc[31:2]) && m_pc[1];
        word = mem_word({m_pc[31:2], 2'b00});
        exp_instr = m_pc[1] ? word[31:16] : word[15:0];
        if (hit) begin
            #1;
            chk("hit_ireq", IReq, 0);
            chk("hit_pc", PC, m_pc);
            tick();
            m_buf_valid = 0;
        end else begin
            for (int i = 0; i < wait_cyc; i++) begin
                IReady = 0;
                IData  = $urandom;
                #1;
                chk("wait_ireq", IReq, 1);
                chk("wait_iaddr", IAddr, {m_pc[31:2], 2'b00});
                chk("wait_pc", PC, m_pc);
                idle_checks("wait");
                tick();
            end
            IReady = 1;
            IData  = word;
            #1;
            chk("acc_ireq", IReq, 1);
            chk("acc_iaddr", IAddr, {m_pc[31:2], 2'b00});
            tick();
            IReady = 0;
            if (!m_pc[1]) begin
                m_buf_valid = 1;
                m_buf_word  = m_pc[31:2];
            end
        end
        CtlValid = ctl_valid; CtlPCMode = mode; ImmIn = imm; BranchTaken = taken;
        JumpRegTarget = target; CtlLsuWidth = lsu; LsuDone = (lsu != 0);
        #1;
        chk("ex_ivalid", InstrValid, 1);
        chk("ex_instr", InstrOut, exp_instr);
        chk("ex_pc", PC, m_pc);
        chk("ex_link", LinkAddr, m_pc + 2);
        chk("ex_ireq", IReq, 0);
        chk("ex_regwe", RegWriteEn, ctl_valid && lsu == 0);
        chk("ex_lsureq", LsuReq, ctl_valid && lsu != 0);
        tick();
        clear_inputs();
        if (!ctl_valid) return;
        if (lsu != 0) begin
            if (abort_lsu) begin
                #1;
                chk("lsu_pre_abort_ireq", IReq, 0);
                do_reset();
                return;
            end
            for (int i = 0; i <= lsu_wait; i++) begin
                LsuDone = (i == lsu_wait);
                #1;
                chk("lsu_ireq", IReq, 0);
                chk("lsu_pc", PC, m_pc);
                idle_checks("lsu");
                tick();
            end
            LsuDone = 0;
            m_pc = m_pc + 2;
        end else begin
            if (!((mode == 2'd0) || (mode == 2'd1 && !taken))) m_buf_valid = 0;
            m_pc = model_next(m_pc, mode, imm, taken, target);
        end
    endtask

    initial begin
        logic [1:0]  r_mode, r_lsu;
        logic [31:0] r_imm, r_tgt;
        bit          r_taken, r_seq;
        int          r_sel;
        clear_inputs();
        Reset = 1;
        do_reset();

        // Reset fetch at RESET_PC, held through three stalls.
        run_instr(3, 1, 2'd0, 0, 0, 0, 2'd0, 0, 0);
        // Sequential hit from the buffer, then JumpReg to 0.
        run_instr(0, 1, 2'd2, 0, 0, 32'h0, 2'd0, 0, 0);
        // Two Inc ops from word 0x4501_4081: 0x4081 fetched, 0x4501 buffered.
        run_instr(1, 1, 2'd0, 0, 0, 0, 2'd0, 0, 0);
        run_instr(0, 1, 2'd0, 0, 0, 0, 2'd0, 0, 0);
        chk("seq_pc_after_two", PC, 32'h4);
        // JumpImm to 0x20, then taken branch back by 16.
        run_instr(0, 1, 2'd3, 32'h1C, 0, 0, 2'd0, 0, 0);
        run_instr(0, 1, 2'd1, 32'hFFFF_FFF0, 1, 0, 2'd0, 0, 0);
        chk("branch_target", PC, 32'h10);
        // Load with a 4-cycle LSU wait.
        run_instr(2, 1, 2'd0, 0, 0, 0, 2'd1, 4, 0);
        // Untaken branch falls through on a buffer hit.
        run_instr(0, 1, 2'd1, 32'h40, 0, 0, 2'd0, 0, 0);
        // JumpReg to an odd target: upper half of word 0x200.
        run_instr(0, 1, 2'd2, 0, 0, 32'h0000_0203, 2'd0, 0, 0);
        chk("jr_pc", PC, 32'h202);
        chk("jr_iaddr", IAddr, 32'h200);
        // Wrap-around at the top of the address space.
        run_instr(1, 1, 2'd2, 0, 0, 32'hFFFF_FFFE, 2'd0, 0, 0);
        run_instr(0, 1, 2'd0, 0, 0, 0, 2'd0, 0, 0);
        chk("wrap_pc", PC, 32'h0);
        // Reset while waiting in LSU_WAIT.
        run_instr(0, 1, 2'd0, 0, 0, 0, 2'd3, 0, 1);
        // Reset while a fetch is stalled.
        IReady = 0;
        #1;
        chk("abort_fetch_ireq", IReq, 1);
        tick();
        do_reset();
        // Illegal instruction halts until reset.
        run_instr(1, 0, 2'd0, 0, 0, 0, 2'd0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            IReady = 1;
            #1;
            chk("halt_flag", Halted, 1);
            chk("halt_ireq", IReq, 0);
            chk("halt_pc", PC, m_pc);
            idle_checks("halt");
            tick();
        end
        do_reset();
        run_instr(0, 1, 2'd0, 0, 0, 0, 2'd0, 0, 0);

        // Randomized instruction stream.
        for (int n = 0; n < 160; n++) begin
            r_lsu = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            do begin
                r_sel   = $urandom_range(0, 7);
                r_mode  = (r_sel < 4) ? 2'd0 : 2'(r_sel - 4);
                r_taken = $urandom_range(0, 1);
                r_imm   = 32'($urandom_range(0, 1023)) - 32'd512;
                r_tgt   = ($urandom_range(0, 3) == 0) ? $urandom : (m_pc + 32'($urandom_range(0, 63)));
                r_seq   = (r_mode == 2'd0) || (r_mode == 2'd1 && !r_taken);
            end while (r_lsu == 0 && !r_seq && model_next(m_pc, r_mode, r_imm, r_taken, r_tgt) == ((m_pc + 2) & ~32'd1));
            run_instr($urandom_range(0, 3), 1, r_mode, r_imm, r_taken, r_tgt, r_lsu,
                      $urandom_range(0, 3), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/compressed_fetch_sequencer.md
COMPRESSED_FETCH_SEQUENCER -- requirements
Module: compressed_fetch_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning PC value loaded on reset (bit 0 ignored).
REQ-002 SHALL have ports, clock and reset first:
- Clock  in  1  sole clock, all state updates on rising edge.
- Reset  in  1  synchronous, active-high.
- IReq  out  1  instruction fetch request.
- IAddr  out  32  word-aligned fetch address.
- IReady  in  1  fetch accepted; IData valid the same cycle.
- IData  in  32  fetched word.
- InstrOut  out  16  halfword presented to the compressed decoder.
- InstrValid  out  1  InstrOut decoded and committed this cycle.
- PC  out  32  address of InstrOut.
- LinkAddr  out  32  PC+2, for link writeback.
- CtlValid  in  1  decoder control lookup non-zero.
- CtlPCMode  in  2  PC write mode: 00 Inc, 01 Branch, 10 JumpReg, 11 JumpImm.
- CtlLsuWidth  in  2  00 = no LSU op.
- ImmIn  in  32  decoder immediate.
- BranchTaken  in  1  ALU flag result.
- JumpRegTarget  in  32  rs1 value.
- RegWriteEn  out  1  register-file write strobe for non-LSU ops.
- LsuReq  out  1  start load/store.
- LsuDone  in  1  LSU op complete.
- Halted  out  1  sequencer stopped on illegal instruction.

Function
REQ-003 SHALL implement states FETCH, EXECUTE, LSU_WAIT, HALT.
REQ-004 FETCH, buffer hit (BufValid and BufWord == PC[31:2] and PC[1]==1): SHALL keep IReq=0, load InstrOut from the buffer, clear BufValid, and go to EXECUTE the next cycle.
REQ-005 FETCH, buffer miss: SHALL hold IReq=1 and IAddr={PC[31:2],2'b00} until IReady, with IAddr stable while waiting.
REQ-006 On an IReady cycle SHALL latch IData[15:0] if PC[1]==0, else IData[31:16], and go to EXECUTE.
- If PC[1]==0, SHALL also store IData[31:16] with BufWord=PC[31:2] and set BufValid.
REQ-007 EXECUTE SHALL last exactly one cycle with InstrValid=1.
REQ-008 EXECUTE with CtlValid=0 SHALL go to HALT without changing PC; HALT is absorbing (Halted=1) until Reset.
REQ-009 EXECUTE with CtlValid=1 and CtlLsuWidth!=0 SHALL pulse LsuReq for one cycle and go to LSU_WAIT.
- LSU_WAIT SHALL hold until LsuDone, then set PC=PC+2 and go to FETCH.
- LsuDone in the same cycle as LsuReq SHALL be ignored.
REQ-010 EXECUTE with CtlValid=1 and CtlLsuWidth==0 SHALL pulse RegWriteEn, update PC and go to FETCH.
REQ-011 Next PC rules (32-bit wrap-around arithmetic, bit 0 forced to 0):
- Inc: PC+2.
- Branch: PC+ImmIn if BranchTaken, else PC+2.
- JumpReg: JumpRegTarget.
- JumpImm: PC+ImmIn.
REQ-012 Any PC update other than PC+2 SHALL clear BufValid.
- PC+2 crossing a word boundary without a buffer hit SHALL fetch normally (miss).
REQ-013 RegWriteEn, LsuReq and InstrValid SHALL be mutually consistent: all zero outside EXECUTE, and RegWriteEn and LsuReq never asserted together.
REQ-014 Throughput SHALL be:
- Buffer hit: 2 cycles per instruction.
- Miss with IReady immediately: 2 cycles per instruction.
- Each wait cycle adds 1.

Reset
REQ-015 On Reset SHALL set state=FETCH, PC=RESET_PC with bit 0 cleared, and BufValid=0.
- IReq, InstrValid, RegWriteEn, LsuReq and Halted SHALL be 0 and InstrOut=16'h0000.
REQ-016 Reset asserted in any state, including FETCH waiting or LSU_WAIT, SHALL abandon the operation.
- IReq and LsuReq SHALL be low in the cycle after Reset is sampled.

Structure
REQ-017 The state enum, the PC write mode enum and the LSU width enum SHALL live in a shared core package, also used by the decoder.
REQ-018 Next-PC computation SHALL be a combinational sub-module next_pc_calc.
- Inputs: PC, CtlPCMode, ImmIn, BranchTaken, JumpRegTarget.
- Output: the next PC.

Verification
REQ-019 Reset with RESET_PC=32'h100 -> IReq=1, IAddr=32'h100; PC=32'h100 held through 3 IReady-low cycles.
REQ-020 Fetch IData=32'h4501_4081 (two Inc ops) at PC 0 -> first instruction 16'h4081; second 16'h4501 from the buffer with no IReq; PC goes 0 -> 2 -> 4.
REQ-021 At PC=32'h20, branch with BranchTaken=1 and ImmIn=32'hFFFF_FFF0 -> next PC=32'h10 and BufValid cleared (IReq asserted for 32'h10).
REQ-022 Load op (CtlLsuWidth=01) -> LsuReq pulse, then 4 cycles in LSU_WAIT with no IReq; LsuDone -> PC+2 and next fetch.
REQ-023 CtlValid=0 (instruction 16'h0000) -> Halted=1 and IReq stays 0 for 10 cycles; Reset -> normal fetch resumes at RESET_PC.
REQ-024 JumpReg with JumpRegTarget=32'h0000_0203 -> PC=32'h202 and IAddr=32'h200; the upper half is selected.
